// File: rtl/axi_read_rr_arbiter.sv
// axi_read_rr_arbiter: round-robin share of one AXI4-Lite read channel
// between NUM_M requesters, with a response-timeout guard (SLVERR on hang).
module axi_read_rr_arbiter #(
   parameter  int NUM_M   = 2,
   parameter  int TIMEOUT = 255,
   parameter  int CNT_W   = 16,
   localparam int ID_W    = $clog2(NUM_M)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_M-1:0]     m_arvalid,
   output logic [NUM_M-1:0]     m_arready,
   input  logic [32*NUM_M-1:0]  m_araddr,
   output logic [NUM_M-1:0]     m_rvalid,
   input  logic [NUM_M-1:0]     m_rready,
   output logic [31:0]          m_rdata,
   output logic [1:0]           m_rresp,
   output logic                 s_arvalid,
   input  logic                 s_arready,
   output logic [31:0]          s_araddr,
   input  logic                 s_rvalid,
   output logic                 s_rready,
   input  logic [31:0]          s_rdata,
   input  logic [1:0]           s_rresp,
   output logic [ID_W-1:0]      grant_id,
   output logic                 busy,
   output logic                 timeout_err
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_ERR,
      ST_DRAIN
   } state_t;

   localparam bit             TO_EN   = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TO_LAST =
      CNT_W'((TIMEOUT != 0) ? TIMEOUT - 1 : 0);

   state_t            r_state;
   state_t            w_next;
   logic [ID_W-1:0]   r_grant_id;
   logic [ID_W-1:0]   r_last_grant;
   logic [31:0]       r_araddr;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_pick_vld;
   logic [ID_W-1:0]   w_pick_id;
   logic [31:0]       w_pick_addr;
   int                w_idx;
   logic [NUM_M-1:0]  w_gmask;
   logic              w_ar_hs;
   logic              w_r_hs;
   logic              w_err_hs;
   logic              w_tmo;

   // Round-robin pick: nearest set request after last_grant wins
   always_comb begin
      w_pick_vld = 1'b0;
      w_pick_id  = '0;
      w_idx      = 0;
      for (int k = NUM_M; k >= 1; k--) begin
         w_idx = (int'(r_last_grant) + k) % NUM_M;
         if (m_arvalid[w_idx]) begin
            w_pick_vld = 1'b1;
            w_pick_id  = ID_W'(w_idx);
         end
      end
      w_pick_addr = m_araddr[32*int'(w_pick_id) +: 32];
   end

   // Handshake and timeout qualifiers for the current owner
   always_comb begin
      w_gmask  = NUM_M'(1) << r_grant_id;
      w_ar_hs  = (r_state == ST_ADDR) & s_arready;
      w_r_hs   = (r_state == ST_DATA) & s_rvalid
               & m_rready[r_grant_id];
      w_err_hs = (r_state == ST_ERR) & m_rready[r_grant_id];
      w_tmo    = (r_state == ST_DATA) & TO_EN
               & (r_cnt == TO_LAST) & ~w_r_hs;
   end

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; a data handshake beats a coincident timeout
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_pick_vld) w_next = ST_ADDR;
         end
         ST_ADDR: begin
            if (w_ar_hs) w_next = ST_DATA;
         end
         ST_DATA: begin
            if (w_r_hs) begin
               w_next = ST_IDLE;
            end else if (w_tmo) begin
               w_next = ST_ERR;
            end
         end
         ST_ERR: begin
            if (w_err_hs) w_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (s_rvalid) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Grant, latched address, fairness pointer and DATA-phase counter
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_grant_id   <= '0;
         r_last_grant <= ID_W'(NUM_M - 1);
         r_araddr     <= '0;
         r_cnt        <= '0;
      end else begin
         if ((r_state == ST_IDLE) && w_pick_vld) begin
            r_grant_id <= w_pick_id;
            r_araddr   <= w_pick_addr;
         end
         if (w_ar_hs) begin
            r_cnt <= '0;
         end else if (r_state == ST_DATA) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_r_hs || w_err_hs) begin
            r_last_grant <= r_grant_id;
         end
      end
   end

   // Output decode: route the channel to the owner or fake an error
   always_comb begin
      m_arready = '0;
      m_rvalid  = '0;
      m_rdata   = '0;
      m_rresp   = '0;
      s_arvalid = 1'b0;
      s_rready  = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
         end
         ST_ADDR: begin
            s_arvalid = 1'b1;
            m_arready = s_arready ? w_gmask : '0;
         end
         ST_DATA: begin
            m_rvalid = s_rvalid ? w_gmask : '0;
            s_rready = m_rready[r_grant_id];
            m_rdata  = s_rdata;
            m_rresp  = s_rresp;
         end
         ST_ERR: begin
            m_rvalid = w_gmask;
            m_rresp  = 2'b10;
         end
         ST_DRAIN: begin
            s_rready = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign s_araddr    = r_araddr;
   assign grant_id    = r_grant_id;
   assign busy        = (r_state != ST_IDLE);
   assign timeout_err = w_tmo;

endmodule

// File: doc/axi_read_rr_arbiter.md
Name: axi_read_rr_arbiter

Overview:
- Round-robin arbiter sharing one AXI4-Lite read channel (AR/R) between NUM_M read requesters: IFU fetch, LSU load, and future requesters such as a DMA or debug port.
- Sits between the requesters and the crossbar read port.
- Allows one outstanding transaction.
- Adds a response-timeout guard: a hung slave returns SLVERR to the requester instead of stalling the core.

Parameters:
- NUM_M, 2, number of requesters (2..8); requester i uses bit/slice i of every m_* vector.
- TIMEOUT, 255, max cycles in DATA before error response; 0 disables the timeout.
- CNT_W, 16, timeout counter width; TIMEOUT must be < 2^CNT_W.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- m_arvalid  in  NUM_M  per-requester address valid.
- m_arready  out  NUM_M  per-requester address accept.
- m_araddr  in  32*NUM_M  requester i address at [32*i+:32].
- m_rvalid  out  NUM_M  per-requester read data valid.
- m_rready  in  NUM_M  per-requester read data ready.
- m_rdata  out  32  read data, shared; valid only with the granted m_rvalid.
- m_rresp  out  2  read response, shared.
- s_arvalid  out  1  slave address valid.
- s_arready  in  1  slave address ready.
- s_araddr  out  32  slave address.
- s_rvalid  in  1  slave data valid.
- s_rready  out  1  slave data ready.
- s_rdata  in  32  slave data.
- s_rresp  in  2  slave response.
- grant_id  out  $clog2(NUM_M)  index of current/last owner.
- busy  out  1  1 whenever state != IDLE.
- timeout_err  out  1  one-cycle pulse when a timeout fires.

Behaviour:
- States: IDLE, ADDR, DATA, ERR, DRAIN.
- Reset (reset=0, async):
  - state=IDLE; grant_id=0; last_grant=NUM_M-1, so requester 0 wins the first tie.
  - counter=0; all valid/ready outputs 0; s_araddr=0.
- IDLE:
  - If any m_arvalid: pick the first set bit scanning from last_grant+1, wrapping modulo NUM_M.
  - Register grant_id and latch the requester's address into s_araddr; go to ADDR.
  - Arbitration costs exactly one cycle. No output valid/ready is asserted in IDLE.
- ADDR:
  - s_arvalid=1, held until s_arready.
  - m_arready[grant_id]=s_arvalid & s_arready, combinational, same cycle as the slave handshake. All other m_arready are 0.
  - On handshake: go to DATA, clear counter.
- DATA:
  - Routing: m_rvalid[grant_id]=s_rvalid; s_rready=m_rready[grant_id]; m_rdata=s_rdata; m_rresp=s_rresp.
  - Non-granted m_rvalid stay 0.
  - On s_rvalid & s_rready: last_grant<=grant_id, go to IDLE. A new arbitration may start the following cycle.
  - Counter increments each DATA cycle. If TIMEOUT!=0 and counter==TIMEOUT-1 without a handshake: go to ERR, pulse timeout_err.
  - If the handshake and the timeout land on the same cycle, the handshake wins: no error.
- ERR:
  - m_rvalid[grant_id]=1, m_rdata=0, m_rresp=2'b10 (SLVERR); s_rready=0.
  - Held until m_rready[grant_id]; then last_grant<=grant_id, go to DRAIN.
- DRAIN:
  - s_rready=1 and the slave response is discarded; no m_rvalid.
  - On s_rvalid: go to IDLE.
  - The timeout does not apply in DRAIN.
- Rules:
  - No timeout in ADDR: the slave must eventually accept.
  - A requester must hold m_arvalid/m_araddr until m_arready (AXI rule). If it drops them after grant, the latched transaction still completes and its response is still delivered.
  - Requests arriving during a transaction wait. Fairness: after requester k completes, k has lowest priority at the next arbitration.
  - grant_id holds its value in IDLE.

Test Plan:
- Single request: m_arvalid=01, addr 0x8000_0000, slave arready on first ADDR cycle, rdata 0xDEADBEEF after 3 cycles -> s_arvalid in cycle 2, m_arready[0] same cycle as s_arready, m_rvalid[0] with 0xDEADBEEF/resp 00, busy drops the next cycle.
- Tie after reset: both requesters valid -> requester 0 served first, then requester 1, then 0 again while both keep requesting (strict alternation).
- Backpressure: slave delays arready 5 cycles; requester 1 holds rready=0 for 4 cycles after rvalid -> s_arvalid stays high, s_rready=0 until requester 1 is ready, data stable, no other grants meanwhile.
- Timeout: TIMEOUT=8, slave never asserts rvalid -> timeout_err pulses once, requester sees rvalid with rresp=10 and rdata=0. Slave later returns rvalid -> consumed in DRAIN, never forwarded. A next request is then served normally.
- Reset mid-transaction: assert reset=0 in DATA -> all outputs 0 asynchronously, without waiting for a clock edge. After release, requester 0 wins a tie.
- Boundary: rvalid on exactly cycle TIMEOUT-1 of DATA -> normal completion, no timeout_err. TIMEOUT=0 with a 1000-cycle slave stall -> no error, completes normally.
